// File: rtl/disp_pkg.sv
// Shared display definitions: the blank BCD code, the digit type and the
// counter width helper used by the scan driver.
package disp_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef logic [3:0] bcd_t;

  // Never returns less than one bit, so SCAN_DIV=2 still gets a usable counter
  function automatic int cntWidth(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_scan_mux_if.sv
// Load channel for the scan driver: a BCD word offered with valid/ready.
interface bcd_scan_mux_if #(
  parameter int NUM_DIGITS = 4
) ();
  import disp_pkg::*;

  logic                        din_valid;
  bcd_t [NUM_DIGITS-1:0]       din;
  logic                        din_ready;

  modport master (output din_valid, output din, input  din_ready);
  modport slave  (input  din_valid, input  din, output din_ready);

endinterface

// File: rtl/bcd_scan_mux_lz_blank.sv
// Combinational leading-zero blanker: zeros above the most significant
// non-zero digit become BCD_BLANK; digit 0 is always kept.
module lz_blank
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit ENABLE     = 1'b1
) (
  input  bcd_t [NUM_DIGITS-1:0] word_i,
  output bcd_t [NUM_DIGITS-1:0] word_o
);

  logic leading;

  always_comb begin
    word_o  = word_i;
    leading = ENABLE;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (word_i[i] == 4'd0)) begin
        word_o[i] = BCD_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with a
// guard interval per slot and frame-aligned loading of new values.
module bcd_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_scan_mux_if.slave         din_if,
  output bcd_t                  sel_o,
  output logic [NUM_DIGITS-1:0] digit_en_o,
  output logic                  frame_tick_o
);

  localparam int CW = cntWidth(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0] active_q, active_d;
  bcd_t [NUM_DIGITS-1:0] pending_q, pending_d;
  bcd_t [NUM_DIGITS-1:0] pendingBlank;
  logic                  pendingFull_q, pendingFull_d;
  bcd_t                  sel_q, sel_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  tick_q, tick_d;
  logic                  lastSlot, boundary, accept;

  lz_blank #(
    .NUM_DIGITS (NUM_DIGITS),
    .ENABLE     (BLANK_LZ)
  ) u_lz_blank (
    .word_i (pending_q),
    .word_o (pendingBlank)
  );

  // Ready depends only on registered state, so there is no path from din_valid
  assign din_if.din_ready = ~pendingFull_q;

  always_comb begin
    lastSlot = (cnt_q == CNT_LAST);
    boundary = lastSlot && (idx_q == IDX_LAST);
    accept   = din_if.din_valid && !pendingFull_q;

    cnt_d = lastSlot ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (lastSlot) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    pending_d     = accept ? din_if.din : pending_q;
    pendingFull_d = pendingFull_q;
    active_d      = active_q;
    if (accept) begin
      pendingFull_d = 1'b1;
    end else if (boundary && pendingFull_q) begin
      pendingFull_d = 1'b0;
      active_d      = pendingBlank;
    end

    sel_d = active_q[idx_q];
    en_d  = '1;
    if ((GUARD == 0) || (cnt_q >= GUARD_C)) begin
      en_d[idx_q] = 1'b0;
    end
    tick_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      active_q      <= {NUM_DIGITS{BCD_BLANK}};
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
      sel_q         <= BCD_BLANK;
      en_q          <= '1;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
      sel_q         <= sel_d;
      en_q          <= en_d;
      tick_q        <= tick_d;
    end
  end

  assign sel_o        = sel_q;
  assign digit_en_o   = en_q;
  assign frame_tick_o = tick_q;

endmodule
